// File: rtl/pong_input_pkg.sv
// Shared definitions for the Pong player-input path.
package pong_input_pkg;

  typedef enum logic {
    SRC_ANALOG,
    SRC_DIGITAL
  } src_t;

  localparam logic [1:0] MODE_Y    = 2'b00;
  localparam logic [1:0] MODE_X    = 2'b01;
  localparam logic [1:0] MODE_INVX = 2'b10;

endpackage

// File: rtl/paddle_accel.sv
// Hold-time acceleration curve: step grows with frames held, clamped to STEP_MAX.
module paddle_accel #(
  parameter int unsigned STEP_MIN  = 1,
  parameter int unsigned STEP_MAX  = 8,
  parameter int unsigned ACC_SHIFT = 3
) (
  input  logic [7:0] hold_frames,
  output logic [3:0] step
);

  logic [8:0] step_raw;

  always_comb begin
    step_raw = 9'(STEP_MIN) + {1'b0, hold_frames >> ACC_SHIFT};
    step     = (step_raw > 9'(STEP_MAX)) ? 4'(STEP_MAX) : step_raw[3:0];
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Per-player paddle position: analog stick or frame-integrated digital buttons,
// whichever was used most recently drives paddle_vpos.
module paddle_ctrl
  import pong_input_pkg::*;
#(
  parameter int unsigned DEADZONE  = 16,
  parameter int unsigned STEP_MIN  = 1,
  parameter int unsigned STEP_MAX  = 8,
  parameter int unsigned ACC_SHIFT = 3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vblank,
  input  logic [1:0]  mode,
  input  logic [15:0] analog,
  input  logic        dig_up,
  input  logic        dig_dn,
  output logic [7:0]  paddle_vpos,
  output logic        src_analog
);

  logic       vblank_q;
  src_t       src_q, src_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] vpos_q, vpos_d;
  logic       src_analog_q, src_analog_d;

  logic [7:0] a_s, a_u;
  logic [8:0] a_abs, acc_dec, acc_inc;
  logic       tick, btn_any, btn_one;
  logic [3:0] step;

  paddle_accel #(
    .STEP_MIN  (STEP_MIN),
    .STEP_MAX  (STEP_MAX),
    .ACC_SHIFT (ACC_SHIFT)
  ) u_accel (
    .hold_frames (hold_q),
    .step        (step)
  );

  always_comb begin
    a_s   = (mode == MODE_Y) ? analog[15:8] : analog[7:0];
    a_u   = mode[1] ? (a_s ^ 8'h7F) : (a_s + 8'h80);
    // 9-bit magnitude so -128 maps to 128 instead of overflowing
    a_abs = a_s[7] ? (9'd0 - {1'b1, a_s}) : {1'b0, a_s};
    tick    = vblank & ~vblank_q;
    btn_any = dig_up | dig_dn;
    btn_one = dig_up ^ dig_dn;
    acc_dec = {1'b0, acc_q} - {5'd0, step};
    acc_inc = {1'b0, acc_q} + {5'd0, step};
  end

  always_comb begin
    src_d  = src_q;
    acc_d  = acc_q;
    hold_d = hold_q;
    unique case (src_q)
      SRC_ANALOG: begin
        // Seed the integrator from the stick so the paddle does not jump;
        // acceleration restarts from STEP_MIN on every fresh button use.
        if (btn_any) begin
          src_d  = SRC_DIGITAL;
          acc_d  = a_u;
          hold_d = 8'd0;
        end
      end
      SRC_DIGITAL: begin
        if (tick) begin
          if (btn_one) begin
            if (dig_up) acc_d = acc_dec[8] ? 8'h00 : acc_dec[7:0];
            else        acc_d = acc_inc[8] ? 8'hFF : acc_inc[7:0];
            hold_d = (hold_q == 8'hFF) ? 8'hFF : hold_q + 8'd1;
          end else begin
            hold_d = 8'd0;
          end
        end
        if (!btn_any && (a_abs > 9'(DEADZONE))) src_d = SRC_ANALOG;
      end
    endcase
  end

  always_comb begin
    vpos_d       = (src_q == SRC_ANALOG) ? a_u : acc_q;
    src_analog_d = (src_q == SRC_ANALOG);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vblank_q     <= 1'b0;
      src_q        <= SRC_ANALOG;
      acc_q        <= 8'h80;
      hold_q       <= 8'd0;
      vpos_q       <= 8'h80;
      src_analog_q <= 1'b1;
    end else begin
      vblank_q     <= vblank;
      src_q        <= src_d;
      acc_q        <= acc_d;
      hold_q       <= hold_d;
      vpos_q       <= vpos_d;
      src_analog_q <= src_analog_d;
    end
  end

  assign paddle_vpos = vpos_q;
  assign src_analog  = src_analog_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: integer reference model plus directed scenarios.
module tb_paddle_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        vblank  = 1'b0;
  logic [1:0]  mode    = 2'b00;
  logic [15:0] analog  = 16'h0000;
  logic        dig_up  = 1'b0;
  logic        dig_dn  = 1'b0;
  logic [7:0]  paddle_vpos;
  logic        src_analog;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  // Reference model state
  int m_acc  = 128;
  int m_hold = 0;
  bit m_dig  = 1'b0;
  bit m_vb   = 1'b0;

  paddle_ctrl dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .vblank      (vblank),
    .mode        (mode),
    .analog      (analog),
    .dig_up      (dig_up),
    .dig_dn      (dig_dn),
    .paddle_vpos (paddle_vpos),
    .src_analog  (src_analog)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sel_s(input logic [1:0] md, input logic [15:0] an);
    logic [7:0] raw;
    raw = (md == 2'b00) ? an[15:8] : an[7:0];
    return int'($signed(raw));
  endfunction

  function automatic int sel_u(input logic [1:0] md, input logic [15:0] an);
    int s;
    s = sel_s(md, an);
    return md[1] ? (127 - s) : (s + 128);
  endfunction

  function automatic int step_of(input int hold);
    int st;
    st = 1 + hold / 8;
    return (st > 8) ? 8 : st;
  endfunction

  always @(posedge clk_sys) begin : model
    int s, au, ovp, st;
    bit osrc, tick;
    if (reset) begin
      m_acc = 128; m_hold = 0; m_dig = 1'b0; m_vb = 1'b0;
      ovp = 128; osrc = 1'b1;
    end else begin
      s    = sel_s(mode, analog);
      au   = sel_u(mode, analog);
      tick = vblank && !m_vb;
      ovp  = m_dig ? m_acc : au;
      osrc = !m_dig;
      if (!m_dig) begin
        if (dig_up || dig_dn) begin
          m_dig = 1'b1; m_acc = au; m_hold = 0;
        end
      end else begin
        if (tick) begin
          if (dig_up != dig_dn) begin
            st     = step_of(m_hold);
            m_acc  = dig_up ? ((m_acc - st < 0) ? 0 : m_acc - st)
                            : ((m_acc + st > 255) ? 255 : m_acc + st);
            m_hold = (m_hold >= 255) ? 255 : m_hold + 1;
          end else begin
            m_hold = 0;
          end
        end
        if (!dig_up && !dig_dn && ((s < 0 ? -s : s) > 16)) m_dig = 1'b0;
      end
      m_vb = vblank;
    end
    exp_q.push_back(ovp * 2 + int'(osrc));
  end

  always @(negedge clk_sys) begin : monitor
    int e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_vpos", paddle_vpos, 8'(e / 2));
      check("sb_src", {7'd0, src_analog}, 8'(e % 2));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic tick_frame();
    vblank = 1'b1; cyc(1);
    vblank = 1'b0; cyc(3);
  endtask

  initial begin
    int exp;
    // 1: reset then Y axis at +0x40
    mode = 2'b00; analog = 16'h4000;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    check("t1_vpos", paddle_vpos, 8'hC0);
    check("t1_src", {7'd0, src_analog}, 8'h01);

    // 2: inverted X axis
    mode = 2'b10; analog = 16'h0080; cyc(1);
    check("t2_m128", paddle_vpos, 8'hFF);
    analog = 16'h007F; cyc(1);
    check("t2_p127", paddle_vpos, 8'h00);
    analog = 16'h0000; cyc(1);
    check("t2_zero", paddle_vpos, 8'h7F);

    // 3: hold down for 20 frames from centre
    mode = 2'b00; analog = 16'h0000; dig_dn = 1'b1;
    cyc(2);
    check("t3_enter_src", {7'd0, src_analog}, 8'h00);
    check("t3_enter_vpos", paddle_vpos, 8'h80);
    exp = 128;
    for (int i = 0; i < 20; i++) begin
      tick_frame();
      exp += step_of(i);
      check("t3_tick", paddle_vpos, 8'(exp));
    end
    check("t3_final", paddle_vpos, 8'hA4);

    // 4: saturate at top from 0x03
    dig_dn = 1'b0; analog = 16'h8300;
    cyc(3);
    check("t4_analog", paddle_vpos, 8'h03);
    dig_up = 1'b1;
    cyc(2);
    check("t4_digital_src", {7'd0, src_analog}, 8'h00);
    check("t4_seed", paddle_vpos, 8'h03);
    exp = 3;
    for (int i = 0; i < 64; i++) begin
      tick_frame();
      exp = (exp - step_of(i) < 0) ? 0 : exp - step_of(i);
      check("t4_up", paddle_vpos, 8'(exp));
    end

    // 5: deadzone boundary
    dig_up = 1'b0; analog = 16'h0A00;
    cyc(3);
    check("t5_dz_src", {7'd0, src_analog}, 8'h00);
    check("t5_dz_vpos", paddle_vpos, 8'h00);
    analog = 16'h1100;
    cyc(1);
    check("t5_lat1", {7'd0, src_analog}, 8'h00);
    cyc(1);
    check("t5_src", {7'd0, src_analog}, 8'h01);
    check("t5_vpos", paddle_vpos, 8'h91);

    // 6: reset while digital at 0xF0 with a coincident tick
    analog = 16'h7000; cyc(1);
    dig_dn = 1'b1; cyc(2);
    check("t6_pre_vpos", paddle_vpos, 8'hF0);
    check("t6_pre_src", {7'd0, src_analog}, 8'h00);
    reset = 1'b1; vblank = 1'b1; cyc(1);
    check("t6_rst_vpos", paddle_vpos, 8'h80);
    check("t6_rst_src", {7'd0, src_analog}, 8'h01);
    reset = 1'b0; vblank = 1'b0; cyc(2);
    check("t6_reenter", {7'd0, src_analog}, 8'h00);
    check("t6_reenter_vpos", paddle_vpos, 8'hF0);

    // Random phase against the reference model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) vblank = ~vblank;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0)
          analog = {8'($urandom_range(0, 40) - 20), 8'($urandom_range(0, 40) - 20)};
        else
          analog = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) dig_up = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) dig_dn = ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    reset = 1'b0; dig_up = 1'b0; dig_dn = 1'b0;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
